// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the multi-cycle Mic-1 style ALU.
//   state_e : control FSM states (IDLE, BUSY, HOLD)
//   sh_e    : post-ALU shifter select, encoded like the sh input
//   func_e  : ALU function, encoded as {f0,f1}
//   flags_t : packed N/Z/V/C result flags
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'd0,
    SH_SLL  = 2'd1,
    SH_SRA1 = 2'd2,
    SH_SRL1 = 2'd3
  } sh_e;

  typedef enum logic [1:0] {
    F_AND  = 2'd0,
    F_OR   = 2'd1,
    F_NOTB = 2'd2,
    F_ADD  = 2'd3
  } func_e;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

  localparam flags_t FLAGS_CLR = '{n: 1'b0, z: 1'b0, v: 1'b0, c: 1'b0};

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: operation/result handshake bundle of alu_mc.
//   master : operand source and result sink (drives in_valid, operands,
//            Mic-1 controls, sh, mul, out_ready)
//   slave  : the ALU (drives in_ready, out_valid, res, res_hi, flags)
interface alu_mc_if #(
  parameter int N = 16
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         f0;
  logic         f1;
  logic         ena;
  logic         enb;
  logic         inva;
  logic         inc;
  logic [1:0]   sh;
  logic         mul;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] res;
  logic [N-1:0] res_hi;
  logic         flag_n;
  logic         flag_z;
  logic         flag_v;
  logic         flag_c;

  modport master (
    output in_valid, a, b, f0, f1, ena, enb, inva, inc, sh, mul, out_ready,
    input  in_ready, out_valid, res, res_hi, flag_n, flag_z, flag_v, flag_c
  );

  modport slave (
    input  in_valid, a, b, f0, f1, ena, enb, inva, inc, sh, mul, out_ready,
    output in_ready, out_valid, res, res_hi, flag_n, flag_z, flag_v, flag_c
  );
endinterface

// File: rtl/alu_mic1_slice.sv
// alu_mic1_slice: combinational Mic-1 ALU core, post-ALU shifter and flags.
//   a, b                 : operands
//   func                 : {f0,f1} function select
//   ena, enb, inva, inc  : operand enables, A invert, carry-in
//   sh                   : shifter select
//   res                  : shifted ALU output
//   flags                : N/Z/V/C of the unshifted ALU output
module alu_mic1_slice
  import alu_pkg::*;
#(
  parameter int N       = 16,
  parameter int SLL_AMT = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  func_e        func,
  input  logic         ena,
  input  logic         enb,
  input  logic         inva,
  input  logic         inc,
  input  sh_e          sh,
  output logic [N-1:0] res,
  output flags_t       flags
);

  logic [N-1:0] a_en_s;
  logic [N-1:0] a_inv_s;
  logic [N-1:0] b_en_s;
  logic [N:0]   sum_s;
  logic [N-1:0] alu_s;

  // ALU core, flag generation and shifter
  always_comb begin
    a_en_s  = ena ? a : {N{1'b0}};
    a_inv_s = inva ? ~a_en_s : a_en_s;
    b_en_s  = enb ? b : {N{1'b0}};
    // One bit wider so the carry out of bit N-1 lands in sum_s[N].
    sum_s   = {1'b0, a_inv_s} + {1'b0, b_en_s} + {{N{1'b0}}, inc};
    alu_s   = {N{1'b0}};
    flags   = FLAGS_CLR;
    case (func)
      F_AND:  alu_s = a_inv_s & b_en_s;
      F_OR:   alu_s = a_inv_s | b_en_s;
      F_NOTB: alu_s = ~b_en_s;
      F_ADD: begin
        alu_s   = sum_s[N-1:0];
        flags.c = sum_s[N];
        // Overflow: like-signed operands producing a result of the other sign.
        flags.v = (a_inv_s[N-1] == b_en_s[N-1]) && (sum_s[N-1] != a_inv_s[N-1]);
      end
      default: alu_s = {N{1'b0}};
    endcase
    flags.n = alu_s[N-1];
    flags.z = (alu_s == {N{1'b0}});
    case (sh)
      SH_NONE: res = alu_s;
      SH_SLL:  res = alu_s << SLL_AMT;
      SH_SRA1: res = {alu_s[N-1], alu_s[N-1:1]};
      SH_SRL1: res = {1'b0, alu_s[N-1:1]};
      default: res = alu_s;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle Mic-1 style ALU with registered result and flags,
// post-ALU shifter, iterative shift-add multiplier and valid/ready on both sides.
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : alu_mc_if slave (operation in, result/flags out)
module alu_mc
  import alu_pkg::*;
#(
  parameter int N       = 16,
  parameter int SLL_AMT = 8
) (
  input logic   clk,
  input logic   rst,
  alu_mc_if.slave bus
);

  localparam int CNT_W = $clog2(N);

  state_e           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [N-1:0]     mcand_r;
  logic [2*N-1:0]   prod_r;
  logic [N-1:0]     res_r;
  logic [N-1:0]     res_hi_r;
  flags_t           flags_r;
  logic             out_valid_r;

  logic             in_ready_s;
  logic             accept_s;
  logic             consume_s;
  logic [N-1:0]     slice_res_s;
  flags_t           slice_flags_s;
  logic [N:0]       prod_add_s;
  logic [2*N-1:0]   prod_nxt_s;

  function automatic flags_t mul_flags(input logic [2*N-1:0] p);
    flags_t f;
    f.n = p[2*N-1];
    f.z = (p == {(2*N){1'b0}});
    f.v = |p[2*N-1:N];
    f.c = 1'b0;
    return f;
  endfunction

  alu_mic1_slice #(
    .N       (N),
    .SLL_AMT (SLL_AMT)
  ) u_slice (
    .a     (bus.a),
    .b     (bus.b),
    .func  (func_e'({bus.f0, bus.f1})),
    .ena   (bus.ena),
    .enb   (bus.enb),
    .inva  (bus.inva),
    .inc   (bus.inc),
    .sh    (sh_e'(bus.sh)),
    .res   (slice_res_s),
    .flags (slice_flags_s)
  );

  // Handshake decode: HOLD can take a new op only in the cycle it is drained
  always_comb begin
    case (state_r)
      IDLE:    in_ready_s = 1'b1;
      HOLD:    in_ready_s = bus.out_ready;
      BUSY:    in_ready_s = 1'b0;
      default: in_ready_s = 1'b0;
    endcase
    accept_s  = bus.in_valid & in_ready_s;
    consume_s = out_valid_r & bus.out_ready;
  end

  // One shift-add step: the multiplier sits in the low half and is shifted out
  // as partial sums enter from the top, so after N steps prod holds a*b.
  always_comb begin
    prod_add_s = {1'b0, prod_r[2*N-1:N]} + {1'b0, mcand_r};
    if (prod_r[0]) begin
      prod_nxt_s = {prod_add_s, prod_r[N-1:1]};
    end else begin
      prod_nxt_s = {1'b0, prod_r[2*N-1:N], prod_r[N-1:1]};
    end
  end

  // Control FSM, multiplier state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      mcand_r     <= {N{1'b0}};
      prod_r      <= {(2*N){1'b0}};
      res_r       <= {N{1'b0}};
      res_hi_r    <= {N{1'b0}};
      flags_r     <= FLAGS_CLR;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE, HOLD: begin
          if (accept_s) begin
            if (bus.mul) begin
              state_r     <= BUSY;
              out_valid_r <= 1'b0;
              mcand_r     <= bus.a;
              prod_r      <= {{N{1'b0}}, bus.b};
              cnt_r       <= {CNT_W{1'b0}};
            end else begin
              state_r     <= HOLD;
              out_valid_r <= 1'b1;
              res_r       <= slice_res_s;
              res_hi_r    <= {N{1'b0}};
              flags_r     <= slice_flags_s;
            end
          end else if (consume_s) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        BUSY: begin
          prod_r <= prod_nxt_s;
          if (cnt_r == CNT_W'(N - 1)) begin
            state_r     <= HOLD;
            cnt_r       <= {CNT_W{1'b0}};
            out_valid_r <= 1'b1;
            res_r       <= prod_nxt_s[N-1:0];
            res_hi_r    <= prod_nxt_s[2*N-1:N];
            flags_r     <= mul_flags(prod_nxt_s);
          end else begin
            state_r <= BUSY;
            cnt_r   <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.res       = res_r;
  assign bus.res_hi    = res_hi_r;
  assign bus.flag_n    = flags_r.n;
  assign bus.flag_z    = flags_r.z;
  assign bus.flag_v    = flags_r.v;
  assign bus.flag_c    = flags_r.c;

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle successor to the team's Mic-1 style 16-bit ALU. Adds a registered result, a post-ALU shifter, registered N/Z/V/C flags, an iterative shift-add multiplier and valid/ready handshakes on both sides. It sits between the register-file read ports and the C-bus writeback in the datapath.

## Interface
Parameters:
- N, 16, operand/result width (≥4)
- SLL_AMT, 8, left-shift amount for sh=01 (1..N-1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready
- a, b  in  N  operands
- f0, f1, ena, enb, inva, inc  in  1 each  Mic-1 ALU control
- sh  in  2  shifter: 00 none, 01 SLL by SLL_AMT, 10 SRA1, 11 SRL1
- mul  in  1  1 = unsigned multiply a*b; ALU controls and sh ignored
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- res  out  N  result (product low half for mul)
- res_hi  out  N  product high half; 0 for ALU ops
- flag_n, flag_z, flag_v, flag_c  out  1 each  flags of the result held on res

## Operation
- ALU core: A' = ena ? a : 0; A'' = inva ? ~A' : A'; B' = enb ? b : 0.
- {f0,f1}: 00 A''&B', 01 A''|B', 10 ~B', 11 A''+B'+inc (N+1-bit sum; carry-in = inc).
- Logic ops (f0f1≠11) ignore inc.
- Shifter applied to ALU output: SLL zero-fills; SRA1 replicates the msb; SRL1 zero-fills.
- Flags come from the ALU output before the shifter:
  - flag_n = msb.
  - flag_z = all-zero.
  - flag_c = carry out of bit N-1 (add only, else 0).
  - flag_v = signed overflow of A''+B' (add only, else 0).
- mul: unsigned 2N-bit product, shift-add over N iterations, one iteration per cycle.
  - res = product[N-1:0], res_hi = product[2N-1:N].
  - flag_z = product==0; flag_n = product[2N-1]; flag_v = (res_hi≠0); flag_c = 0.
- FSM states IDLE, BUSY, HOLD:
  - IDLE: in_ready=1. On accept of an ALU op -> HOLD with the result registered. On accept of mul -> BUSY: operands latched, accumulator cleared, iteration counter = 0.
  - BUSY: in_ready=0. The counter increments each cycle; after iteration N-1 -> HOLD.
  - HOLD: out_valid=1; res/res_hi/flags are stable until the result is consumed. in_ready = out_ready. If consumed and no new accept -> IDLE. If consumed and a new op is accepted in the same cycle -> behave as an accept in IDLE (back-to-back).
- Inputs are sampled only on accept; changes at any other time have no effect.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, res=0, res_hi=0, all flags 0, counter 0.
- ALU op latency: accepted at edge k -> out_valid=1 after edge k. Throughput is one per cycle with out_ready held high.
- mul latency: accepted at edge k -> out_valid=1 after edge k+N (N BUSY cycles).
- Backpressure: while out_ready=0 in HOLD, all outputs are frozen and in_ready=0.
- rst asserted in any state, including mid-BUSY: the next edge forces the reset values. A multiply in progress is discarded and produces no out_valid.
- Counter width is $clog2(N). There is no wrap beyond N-1.

## Structure
- Shared package alu_pkg:
  - state_e {IDLE, BUSY, HOLD}
  - sh_e {SH_NONE, SH_SLL, SH_SRA1, SH_SRL1}
  - func_e {F_AND, F_OR, F_NOTB, F_ADD}
- Sub-module alu_mic1_slice: combinational, parameter N. Contains the ALU core, shifter and flag generation. Instantiated once; alu_mc owns the FSM, the multiplier and the output registers.

## Test plan
All vectors use N=16, SLL_AMT=8.
- a=1, b=2, f0f1=11, ena=enb=1, inva=inc=0 -> res=3, all flags 0, out_valid one cycle after accept.
- a=1, b=2, f0f1=11, ena=enb=inva=inc=1 (B-A) -> res=1, c=1. a=0x7FFF, b=1, add -> res=0x8000, n=1, v=1. a=0xFFFF, b=1, add -> res=0, z=1, c=1, v=0.
- Shifter:
  - a=0x00AB pass-through (f0f1=01, ena=1, enb=0), sh=01 -> res=0xAB00.
  - a=0x8002, sh=10 -> res=0xC001.
  - a=0x8002, sh=11 -> res=0x4001.
- mul a=0xFFFF, b=0xFFFF -> res=0x0001, res_hi=0xFFFE, v=1, out_valid exactly 16 cycles after accept, in_ready=0 throughout BUSY.
- out_ready=0 for 5 cycles in HOLD -> outputs stable and in_ready=0. Then out_ready=1 with in_valid=1 -> the new op is accepted in the same cycle and its result is valid on the next cycle.
- rst pulsed at BUSY iteration 7 -> next cycle IDLE, out_valid=0, res=0, in_ready=1. No stale result appears afterwards.
